// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl
//   Next-PC sequencer for the RV32I fetch stage. Owns the PC, issues I-cache
//   fetch requests over a valid/ready handshake, and redirects fetch on a
//   resolved EX-stage jump or taken branch. A redirect that arrives while a
//   request is stuck waiting for ready is deferred until that handshake
//   completes. Misaligned targets are trapped to TRAP_VEC.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   stall           hazard stall, freezes sequential PC advance
//   ex_valid        EX stage holds a valid instruction
//   ex_opcode       EX-stage opcode (JAL/JALR/BRANCH redirect)
//   ex_br_taken     branch comparator result
//   jb_out          resolved jump/branch target
//   im_req_ready    I-cache accepts the request this cycle
//   im_req_valid    fetch request valid
//   im_addr         fetch address (current PC)
//   flush           kill IF/ID contents and any returning fetch response
//   misalign_exc    one-cycle pulse on a misaligned target
//   misalign_addr   last offending target
//   redirect_cnt    number of accepted redirects (wraps)
//
// state      | meaning
// -----------+---------------------------------------------------------
// RUN        | normal sequential fetch, redirects accepted
// WAIT_REDIR | redirect captured, waiting for in-flight request to finish

module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic        ex_br_taken,
  input  logic [31:0] jb_out,
  input  logic        im_req_ready,
  output logic        im_req_valid,
  output logic [31:0] im_addr,
  output logic        flush,
  output logic        misalign_exc,
  output logic [31:0] misalign_addr,
  output logic [31:0] redirect_cnt
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    WAIT_REDIR = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_pending_q, req_pending_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic [31:0] misalign_addr_q, misalign_addr_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  logic        is_jump;
  logic        redir;
  logic        xfer;
  logic        tgt_misaligned;
  logic [31:0] target;

  assign is_jump = (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR) ||
                   ((ex_opcode == OP_BRANCH) && ex_br_taken);
  assign redir   = !rst && ex_valid && (state_q == RUN) && is_jump;

  // A request that has been raised without ready stays up regardless of stall.
  assign im_req_valid   = !rst && (req_pending_q || !stall);
  assign xfer           = im_req_valid && im_req_ready;
  assign tgt_misaligned = (jb_out[1:0] != 2'b00);

  assign im_addr       = pc_q;
  assign misalign_addr = misalign_addr_q;
  assign redirect_cnt  = redirect_cnt_q;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    req_pending_d   = im_req_valid && !im_req_ready;
    redir_tgt_d     = redir_tgt_q;
    misalign_addr_d = misalign_addr_q;
    redirect_cnt_d  = redirect_cnt_q;
    flush           = 1'b0;
    misalign_exc    = 1'b0;
    target          = {jb_out[31:2], 2'b00};

    case (state_q)
      RUN: begin
        if (redir) begin
          flush          = 1'b1;
          redirect_cnt_d = redirect_cnt_q + 32'd1;
          if (tgt_misaligned) begin
            misalign_exc    = 1'b1;
            misalign_addr_d = jb_out;
            target          = TRAP_VEC;
          end
          // Retargeting the PC mid-handshake would change im_addr under a
          // pending request, so park the target until the cache accepts.
          if (!im_req_valid || im_req_ready) begin
            pc_d = target;
          end else begin
            redir_tgt_d = target;
            state_d     = WAIT_REDIR;
          end
        end else if (xfer && !stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      WAIT_REDIR: begin
        flush = !rst;
        if (xfer) begin
          pc_d    = redir_tgt_q;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      pc_q            <= RESET_PC;
      req_pending_q   <= 1'b0;
      redir_tgt_q     <= 32'h0;
      misalign_addr_q <= 32'h0;
      redirect_cnt_q  <= 32'h0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      req_pending_q   <= req_pending_d;
      redir_tgt_q     <= redir_tgt_d;
      misalign_addr_q <= misalign_addr_d;
      redirect_cnt_q  <= redirect_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
module tb_fetch_redirect_ctrl;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic        ex_br_taken;
  logic [31:0] jb_out;
  logic        im_req_ready;
  logic        im_req_valid;
  logic [31:0] im_addr;
  logic        flush;
  logic        misalign_exc;
  logic [31:0] misalign_addr;
  logic [31:0] redirect_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_redirect_ctrl #(
    .RESET_PC(32'h0000_0000),
    .TRAP_VEC(32'h0000_0100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_opcode    (ex_opcode),
    .ex_br_taken  (ex_br_taken),
    .jb_out       (jb_out),
    .im_req_ready (im_req_ready),
    .im_req_valid (im_req_valid),
    .im_addr      (im_addr),
    .flush        (flush),
    .misalign_exc (misalign_exc),
    .misalign_addr(misalign_addr),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one clock, then settle just after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; ex_valid = 1'b0; ex_opcode = OP_ADDI;
    ex_br_taken = 1'b0; jb_out = 32'h0; im_req_ready = 1'b1;

    // reset
    #1;
    check_val("rst_valid", {31'h0, im_req_valid}, 32'h0);
    check_val("rst_flush", {31'h0, flush}, 32'h0);
    cyc(); cyc();
    #1;
    check_val("rst_addr", im_addr, 32'h0);
    check_val("rst_cnt", redirect_cnt, 32'h0);
    check_val("rst_maddr", misalign_addr, 32'h0);

    // free run
    rst = 1'b0; #1;
    check_val("run_valid", {31'h0, im_req_valid}, 32'h1);
    check_val("run_a0", im_addr, 32'h0);
    cyc(); #1; check_val("run_a4", im_addr, 32'h4);
    cyc(); #1; check_val("run_a8", im_addr, 32'h8);
    cyc(); #1; check_val("run_aC", im_addr, 32'hC);
    check_val("run_flush", {31'h0, flush}, 32'h0);
    check_val("run_cnt", redirect_cnt, 32'h0);

    // JAL to 0x200, cache ready
    ex_valid = 1'b1; ex_opcode = OP_JAL; jb_out = 32'h200; #1;
    check_val("jal_flush", {31'h0, flush}, 32'h1);
    check_val("jal_exc", {31'h0, misalign_exc}, 32'h0);
    cyc(); ex_valid = 1'b0; #1;
    check_val("jal_addr", im_addr, 32'h200);
    check_val("jal_flush_off", {31'h0, flush}, 32'h0);
    check_val("jal_cnt", redirect_cnt, 32'h1);

    // BRANCH not taken, then taken
    ex_valid = 1'b1; ex_opcode = OP_BRANCH; ex_br_taken = 1'b0; jb_out = 32'h300; #1;
    check_val("bnt_flush", {31'h0, flush}, 32'h0);
    cyc(); #1;
    check_val("bnt_addr", im_addr, 32'h204);
    ex_br_taken = 1'b1; #1;
    check_val("bt_flush", {31'h0, flush}, 32'h1);
    cyc(); ex_valid = 1'b0; ex_br_taken = 1'b0; #1;
    check_val("bt_addr", im_addr, 32'h300);
    check_val("bt_cnt", redirect_cnt, 32'h2);

    // JALR while cache not ready for 3 cycles
    ex_valid = 1'b1; ex_opcode = OP_JALR; jb_out = 32'h400; im_req_ready = 1'b0; #1;
    check_val("wr_flush1", {31'h0, flush}, 32'h1);
    check_val("wr_addr1", im_addr, 32'h300);
    cyc(); ex_valid = 1'b0; #1;
    check_val("wr_flush2", {31'h0, flush}, 32'h1);
    check_val("wr_addr2", im_addr, 32'h300);
    check_val("wr_valid2", {31'h0, im_req_valid}, 32'h1);
    check_val("wr_cnt", redirect_cnt, 32'h3);
    cyc(); ex_valid = 1'b1; ex_opcode = OP_JAL; jb_out = 32'h800; #1;
    check_val("wr_flush3", {31'h0, flush}, 32'h1);
    check_val("wr_addr3", im_addr, 32'h300);
    cyc(); ex_valid = 1'b0; im_req_ready = 1'b1; #1;
    check_val("wr_flush4", {31'h0, flush}, 32'h1);
    check_val("wr_addr4", im_addr, 32'h300);
    cyc(); #1;
    check_val("wr_addr_tgt", im_addr, 32'h400);
    check_val("wr_flush_off", {31'h0, flush}, 32'h0);
    check_val("wr_cnt_after", redirect_cnt, 32'h3);

    // misaligned JAL
    ex_valid = 1'b1; ex_opcode = OP_JAL; jb_out = 32'h202; #1;
    check_val("mis_exc", {31'h0, misalign_exc}, 32'h1);
    check_val("mis_flush", {31'h0, flush}, 32'h1);
    cyc(); ex_valid = 1'b0; #1;
    check_val("mis_addr_trap", im_addr, 32'h100);
    check_val("mis_exc_off", {31'h0, misalign_exc}, 32'h0);
    check_val("mis_maddr", misalign_addr, 32'h202);
    check_val("mis_cnt", redirect_cnt, 32'h4);

    // stall with nothing pending
    stall = 1'b1; #1;
    check_val("st_valid1", {31'h0, im_req_valid}, 32'h0);
    cyc(); #1;
    check_val("st_valid2", {31'h0, im_req_valid}, 32'h0);
    check_val("st_addr2", im_addr, 32'h100);
    cyc(); stall = 1'b0; #1;
    check_val("st_addr3", im_addr, 32'h100);
    check_val("st_valid3", {31'h0, im_req_valid}, 32'h1);
    cyc(); #1;
    check_val("st_addr4", im_addr, 32'h104);

    // stall arrives while a request is pending: request completes, PC holds
    im_req_ready = 1'b0; #1;
    check_val("sp_valid1", {31'h0, im_req_valid}, 32'h1);
    cyc(); stall = 1'b1; #1;
    check_val("sp_valid2", {31'h0, im_req_valid}, 32'h1);
    check_val("sp_addr2", im_addr, 32'h104);
    cyc(); im_req_ready = 1'b1; #1;
    check_val("sp_valid3", {31'h0, im_req_valid}, 32'h1);
    cyc(); #1;
    check_val("sp_valid4", {31'h0, im_req_valid}, 32'h0);
    check_val("sp_addr4", im_addr, 32'h104);
    stall = 1'b0;

    // reset during WAIT_REDIR
    cyc();
    ex_valid = 1'b1; ex_opcode = OP_JAL; jb_out = 32'h500; im_req_ready = 1'b0; #1;
    cyc(); ex_valid = 1'b0; #1;
    check_val("rw_flush", {31'h0, flush}, 32'h1);
    check_val("rw_cnt", redirect_cnt, 32'h5);
    rst = 1'b1; #1;
    check_val("rw_rst_flush", {31'h0, flush}, 32'h0);
    check_val("rw_rst_valid", {31'h0, im_req_valid}, 32'h0);
    cyc(); rst = 1'b0; im_req_ready = 1'b1; #1;
    check_val("rw_addr", im_addr, 32'h0);
    check_val("rw_cnt0", redirect_cnt, 32'h0);
    check_val("rw_flush0", {31'h0, flush}, 32'h0);
    cyc(); #1;
    check_val("rw_addr_next", im_addr, 32'h4);

    // PC wrap at top of address space
    ex_valid = 1'b1; ex_opcode = OP_JAL; jb_out = 32'hFFFF_FFFC; #1;
    cyc(); ex_valid = 1'b0; #1;
    check_val("wrap_top", im_addr, 32'hFFFF_FFFC);
    cyc(); #1;
    check_val("wrap_zero", im_addr, 32'h0);
    check_val("wrap_cnt", redirect_cnt, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
